// File: rtl/recovery_level_sequencer.sv
// Sequencer for the error-recovery multiplier: drives the one-hot partial-result select,
// waits the datapath latency, then returns the captured product over a valid/ready channel.
module recovery_level_sequencer #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned LAT   = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_level,
    input  logic [3:0]           req_tag,
    output logic [4:0]           sel,
    output logic                 dp_en,
    input  logic [2*WIDTH-1:0]   mux_in,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_data,
    output logic [2:0]           rsp_level,
    output logic [3:0]           rsp_tag,
    output logic                 busy,
    output logic                 err_level
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = 4;
    localparam int unsigned LW = 3;
    localparam int unsigned TW = 4;
    localparam int unsigned SW = 5;
    localparam logic [LW-1:0] MAX_LEVEL = LW'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   lvl_q, lvl_d;
    logic [TW-1:0]   tag_q, tag_d;
    logic [SW-1:0]   sel_d;
    logic            dp_en_d;
    logic            rsp_valid_d;
    logic [DW-1:0]   rsp_data_d;
    logic [LW-1:0]   rsp_level_d;
    logic [TW-1:0]   rsp_tag_d;
    logic            err_level_d;

    // Next-state and next-register values; everything holds unless a transition updates it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lvl_d       = lvl_q;
        tag_d       = tag_q;
        sel_d       = sel;
        dp_en_d     = dp_en;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_level_d = rsp_level;
        rsp_tag_d   = rsp_tag;
        err_level_d = err_level;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(LAT);
                    dp_en_d = 1'b1;
                    tag_d   = req_tag;
                    // Out-of-range levels fall back to the strongest recovery level.
                    if (req_level > MAX_LEVEL) begin
                        lvl_d       = MAX_LEVEL;
                        err_level_d = 1'b1;
                    end else begin
                        lvl_d = req_level;
                    end
                    sel_d = SW'(1) << lvl_d;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = S_RESP;
                    rsp_data_d  = mux_in;
                    rsp_valid_d = 1'b1;
                    rsp_level_d = lvl_q;
                    rsp_tag_d   = tag_q;
                    dp_en_d     = 1'b0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; req_ready/busy are registered decodes of the next state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lvl_q     <= '0;
            tag_q     <= '0;
            sel       <= SW'(1);
            dp_en     <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_level <= '0;
            rsp_tag   <= '0;
            busy      <= 1'b0;
            err_level <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            tag_q     <= tag_d;
            sel       <= sel_d;
            dp_en     <= dp_en_d;
            req_ready <= (state_d == S_IDLE);
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_level <= rsp_level_d;
            rsp_tag   <= rsp_tag_d;
            busy      <= (state_d != S_IDLE);
            err_level <= err_level_d;
        end
    end

endmodule

// File: tb/tb_recovery_level_sequencer.sv
// Directed bench for recovery_level_sequencer: LAT=2 instance for most scenarios, LAT=1 instance for latency.
module tb_recovery_level_sequencer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DW    = 2 * WIDTH;

    logic          Clk;
    logic          Rst;
    int unsigned   cyc;
    int            checks;
    int            failures;

    logic          req_valid, req_ready, dp_en, rsp_valid, rsp_ready, busy, err_level;
    logic [2:0]    req_level, rsp_level;
    logic [3:0]    req_tag, rsp_tag;
    logic [4:0]    sel;
    logic [DW-1:0] mux_in, rsp_data;

    logic          req_valid1, req_ready1, dp_en1, rsp_valid1, rsp_ready1, busy1, err_level1;
    logic [2:0]    req_level1, rsp_level1;
    logic [3:0]    req_tag1, rsp_tag1;
    logic [4:0]    sel1;
    logic [DW-1:0] mux_in1, rsp_data1;

    // Mux result carries the cycle it was sampled in, so a capture on the wrong edge shows up.
    assign mux_in  = {16'(cyc), 11'd0, sel};
    assign mux_in1 = {16'(cyc), 11'd0, sel1};

    recovery_level_sequencer #(.WIDTH(WIDTH), .LAT(2)) dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_level(req_level), .req_tag(req_tag), .sel(sel), .dp_en(dp_en),
        .mux_in(mux_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_level(rsp_level), .rsp_tag(rsp_tag),
        .busy(busy), .err_level(err_level)
    );

    recovery_level_sequencer #(.WIDTH(WIDTH), .LAT(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_level(req_level1), .req_tag(req_tag1), .sel(sel1), .dp_en(dp_en1),
        .mux_in(mux_in1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_data(rsp_data1), .rsp_level(rsp_level1), .rsp_tag(rsp_tag1),
        .busy(busy1), .err_level(err_level1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        step();
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        checks++; if (sel !== 5'b00001) begin failures++; $display("FAIL rst_sel got=%b exp=00001", sel); end
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || dp_en !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=000", rsp_valid, busy, dp_en); end
        checks++; if (rsp_data !== '0 || rsp_tag !== 4'd0 || rsp_level !== 3'd0 || err_level !== 1'b0) begin failures++; $display("FAIL rst_rsp got=%h/%h/%h/%b exp=0", rsp_data, rsp_tag, rsp_level, err_level); end
        step();
        Rst = 1'b0;
        step();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
        // Start an operation with an illegal level, then reset it mid-flight.
        req_valid = 1'b1; req_level = 3'd7; req_tag = 4'd9;
        step();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || err_level !== 1'b1) begin failures++; $display("FAIL rst_pre_busy_err got=%b%b exp=11", busy, err_level); end
        Rst = 1'b1;
        step();
        step();
        checks++; if (sel !== 5'b00001) begin failures++; $display("FAIL rst_mid_sel got=%b exp=00001", sel); end
        checks++; if (rsp_valid !== 1'b0 || err_level !== 1'b0 || busy !== 1'b0 || dp_en !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%b%b%b%b exp=0000", rsp_valid, err_level, busy, dp_en); end
        Rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_discard cyc%0d got=%b exp=0", i, rsp_valid); end
        end
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_idle got=%b%b exp=10", req_ready, busy); end
    endtask

    task automatic test_level_sweep();
        logic [4:0]  sel_tab [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
        int unsigned c;
        logic [DW-1:0] exp_data;
        rsp_ready = 1'b1;
        for (int l = 0; l < 5; l++) begin
            c = cyc;
            req_valid = 1'b1; req_level = 3'(l); req_tag = 4'(l);
            step();
            req_valid = 1'b0;
            checks++; if (sel !== sel_tab[l] || dp_en !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL sweep_accept l%0d got sel=%b en=%b rdy=%b exp sel=%b en=1 rdy=0", l, sel, dp_en, req_ready, sel_tab[l]); end
            step();
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL sweep_early_valid l%0d got=%b exp=0", l, rsp_valid); end
            step();
            exp_data = {16'(c + 2), 11'd0, sel_tab[l]};
            checks++; if (rsp_valid !== 1'b1 || dp_en !== 1'b0) begin failures++; $display("FAIL sweep_valid l%0d got v=%b en=%b exp v=1 en=0", l, rsp_valid, dp_en); end
            checks++; if (rsp_data !== exp_data || rsp_tag !== 4'(l) || rsp_level !== 3'(l)) begin failures++; $display("FAIL sweep_rsp l%0d got=%h/%h/%h exp=%h/%h/%h", l, rsp_data, rsp_tag, rsp_level, exp_data, 4'(l), 3'(l)); end
            step();
            checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL sweep_handshake l%0d got v=%b rdy=%b exp v=0 rdy=1", l, rsp_valid, req_ready); end
        end
    endtask

    task automatic test_back_pressure();
        int unsigned c;
        logic [DW-1:0] exp_data;
        rsp_ready = 1'b0;
        c = cyc;
        req_valid = 1'b1; req_level = 3'd2; req_tag = 4'hA;
        step();
        req_valid = 1'b0;
        step();
        step();
        exp_data = {16'(c + 2), 11'd0, 5'b00100};
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_data) begin failures++; $display("FAIL bp_first got v=%b d=%h exp v=1 d=%h", rsp_valid, rsp_data, exp_data); end
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                req_valid = 1'b1; req_level = 3'd0; req_tag = 4'd5;
            end
            step();
            req_valid = 1'b0;
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_tag !== 4'hA || rsp_level !== 3'd2 || req_ready !== 1'b0 || sel !== 5'b00100) begin
                failures++;
                $display("FAIL bp_hold cyc%0d got v=%b d=%h t=%h l=%h rdy=%b sel=%b exp v=1 d=%h t=a l=2 rdy=0 sel=00100", i, rsp_valid, rsp_data, rsp_tag, rsp_level, req_ready, sel, exp_data);
            end
        end
        rsp_ready = 1'b1;
        step();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release got v=%b busy=%b exp 0/0", rsp_valid, busy); end
        step();
        checks++; if (busy !== 1'b0 || sel !== 5'b00100 || rsp_data !== exp_data) begin failures++; $display("FAIL bp_no_accept got busy=%b sel=%b d=%h exp 0/00100/%h", busy, sel, rsp_data, exp_data); end
    endtask

    task automatic test_invalid_level();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_level = 3'd6; req_tag = 4'd3;
        step();
        req_valid = 1'b0;
        checks++; if (sel !== 5'b10000 || err_level !== 1'b1) begin failures++; $display("FAIL inv_sel got sel=%b err=%b exp 10000/1", sel, err_level); end
        step();
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_level !== 3'd4 || rsp_tag !== 4'd3) begin failures++; $display("FAIL inv_rsp got v=%b l=%h t=%h exp 1/4/3", rsp_valid, rsp_level, rsp_tag); end
        step();
        req_valid = 1'b1; req_level = 3'd1; req_tag = 4'd4;
        step();
        req_valid = 1'b0;
        checks++; if (sel !== 5'b00010 || err_level !== 1'b1) begin failures++; $display("FAIL inv_sticky got sel=%b err=%b exp 00010/1", sel, err_level); end
        step();
        step();
        checks++; if (rsp_level !== 3'd1 || err_level !== 1'b1) begin failures++; $display("FAIL inv_next_rsp got l=%h err=%b exp 1/1", rsp_level, err_level); end
        step();
    endtask

    task automatic test_select_hold();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_level = 3'd3; req_tag = 4'd7;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (sel !== 5'b01000 || dp_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL hold cyc%0d got sel=%b en=%b busy=%b exp 01000/0/0", i, sel, dp_en, busy); end
        end
    endtask

    task automatic test_lat1();
        int unsigned c;
        logic [DW-1:0] exp_data;
        rsp_ready1 = 1'b1;
        c = cyc;
        req_valid1 = 1'b1; req_level1 = 3'd2; req_tag1 = 4'd6;
        step();
        req_valid1 = 1'b0;
        checks++; if (rsp_valid1 !== 1'b0 || dp_en1 !== 1'b1 || sel1 !== 5'b00100) begin failures++; $display("FAIL lat1_accept got v=%b en=%b sel=%b exp 0/1/00100", rsp_valid1, dp_en1, sel1); end
        step();
        exp_data = {16'(c + 1), 11'd0, 5'b00100};
        checks++; if (rsp_valid1 !== 1'b1 || rsp_data1 !== exp_data || rsp_tag1 !== 4'd6) begin failures++; $display("FAIL lat1_rsp got v=%b d=%h t=%h exp 1/%h/6", rsp_valid1, rsp_data1, rsp_tag1, exp_data); end
        step();
        checks++; if (rsp_valid1 !== 1'b0 || req_ready1 !== 1'b1) begin failures++; $display("FAIL lat1_handshake got v=%b rdy=%b exp 0/1", rsp_valid1, req_ready1); end
    endtask

    initial begin
        checks = 0; failures = 0;
        Rst = 1'b1;
        req_valid = 1'b0; req_level = 3'd0; req_tag = 4'd0; rsp_ready = 1'b0;
        req_valid1 = 1'b0; req_level1 = 3'd0; req_tag1 = 4'd0; rsp_ready1 = 1'b0;
        test_reset();
        test_level_sweep();
        test_back_pressure();
        test_invalid_level();
        test_select_hold();
        test_lat1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
